// File: rtl/coffee_ctrl_multi_if.sv
// Front-panel / actuator bundle for coffee_ctrl_multi; suffixes are from the controller's point of view.
// Sugar request/actuator signals exist only when COFFEE_SUGAR_EN is defined.
interface coffee_ctrl_multi_if #(
    parameter int NUM_DRINKS = 4,
    parameter int SEL_W      = 3,
    parameter int NUM_SENS   = 5
);
    logic                  start_i;
    logic [SEL_W-1:0]      sel_i;
    logic [NUM_SENS-1:0]   sens_i;
    logic                  busy_o;
    logic [NUM_DRINKS-1:0] drink_o;
    logic [NUM_SENS-1:0]   err_o;
    logic                  bad_sel_o;
    logic                  cup_o;
    logic                  heat_o;
    logic                  pour_o;
    logic                  mix_o;
    logic                  done_o;
`ifdef COFFEE_SUGAR_EN
    logic [1:0]            sugar_req_i;
    logic                  sugar_o;

    modport master (
        output start_i, sel_i, sens_i, sugar_req_i,
        input  busy_o, drink_o, err_o, bad_sel_o, cup_o, heat_o, pour_o, mix_o, done_o, sugar_o
    );
    modport slave (
        input  start_i, sel_i, sens_i, sugar_req_i,
        output busy_o, drink_o, err_o, bad_sel_o, cup_o, heat_o, pour_o, mix_o, done_o, sugar_o
    );
`else
    modport master (
        output start_i, sel_i, sens_i,
        input  busy_o, drink_o, err_o, bad_sel_o, cup_o, heat_o, pour_o, mix_o, done_o
    );
    modport slave (
        input  start_i, sel_i, sens_i,
        output busy_o, drink_o, err_o, bad_sel_o, cup_o, heat_o, pour_o, mix_o, done_o
    );
`endif
endinterface

// File: rtl/coffee_ctrl_multi.sv
// Multi-recipe coffee controller: timed CUP/HEAT/POUR/[SUGAR]/MIX sequence with supply-loss abort.
// Define COFFEE_SUGAR_EN to add the sugar request input, sugar actuator and SUGAR phase.
// state | meaning: IDLE wait START | CHECK supply test | ERROR supply missing | CUP,HEAT,POUR,SUGAR,MIX timed phases | DONE finish pulse
module coffee_ctrl_multi #(
    parameter int                    NUM_DRINKS   = 4,
    parameter int                    SEL_W        = 3,
    parameter int                    NUM_SENS     = 5,
    parameter int                    CNT_W        = 8,
    parameter int                    HEAT_CYCLES  = 8,
    parameter int                    POUR_BASE    = 4,
    parameter int                    MIX_CYCLES   = 6,
`ifdef COFFEE_SUGAR_EN
    parameter int                    SUGAR_CYCLES = 3,
`endif
    parameter logic [NUM_DRINKS-1:0] MIX_MASK     = 4'b1010
) (
    input logic                clk,
    input logic                rst,
    coffee_ctrl_multi_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_ERROR,
        S_CUP,
        S_HEAT,
        S_POUR,
`ifdef COFFEE_SUGAR_EN
        S_SUGAR,
`endif
        S_MIX,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] HEAT_M1      = CNT_W'(HEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIX_M1       = CNT_W'(MIX_CYCLES - 1);
    localparam logic [SEL_W:0]   NUM_DRINKS_X = (SEL_W+1)'(NUM_DRINKS);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic                  bad_sel_q, bad_sel_d;
    logic [NUM_DRINKS-1:0] drink_oh;
    logic [CNT_W-1:0]      pour_m1;
    logic                  mix_sel;
    logic                  sens_ok;
    logic                  sel_valid;
    logic                  phase_active;
`ifdef COFFEE_SUGAR_EN
    logic [1:0]            sug_q, sug_d;
    logic [CNT_W-1:0]      sug_m1;
`endif

    always_comb begin
        drink_oh = '0;
        for (int i = 0; i < NUM_DRINKS; i++) begin
            if (sel_q == SEL_W'(i)) drink_oh[i] = 1'b1;
        end
    end

    // Pour length wraps cleanly at CNT_W bits: N = 2**CNT_W yields N-1 = all ones.
    assign pour_m1   = CNT_W'(POUR_BASE) * (CNT_W'(sel_q) + CNT_W'(1)) - CNT_W'(1);
    assign mix_sel   = |(drink_oh & MIX_MASK);
    assign sens_ok   = &bus.sens_i;
    assign sel_valid = {1'b0, bus.sel_i} < NUM_DRINKS_X;
`ifdef COFFEE_SUGAR_EN
    assign sug_m1    = CNT_W'(SUGAR_CYCLES) * CNT_W'(sug_q) - CNT_W'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            bad_sel_q <= 1'b0;
`ifdef COFFEE_SUGAR_EN
            sug_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            bad_sel_q <= bad_sel_d;
`ifdef COFFEE_SUGAR_EN
            sug_q     <= sug_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        bad_sel_d = 1'b0;
`ifdef COFFEE_SUGAR_EN
        sug_d     = sug_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    if (sel_valid) begin
                        sel_d   = bus.sel_i;
`ifdef COFFEE_SUGAR_EN
                        sug_d   = bus.sugar_req_i;
`endif
                        state_d = S_CHECK;
                    end else begin
                        bad_sel_d = 1'b1;
                    end
                end
            end
            S_CHECK: state_d = sens_ok ? S_CUP : S_ERROR;
            S_ERROR: begin
                if (sens_ok && !bus.start_i) state_d = S_IDLE;
            end
            S_CUP: begin
                if (!sens_ok) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_HEAT;
                    cnt_d   = HEAT_M1;
                end
            end
            S_HEAT: begin
                if (!sens_ok) begin
                    state_d = S_ERROR;
                end else if (cnt_q == '0) begin
                    state_d = S_POUR;
                    cnt_d   = pour_m1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_POUR: begin
                if (!sens_ok) begin
                    state_d = S_ERROR;
                end else if (cnt_q == '0) begin
`ifdef COFFEE_SUGAR_EN
                    if (sug_q != 2'd0) begin
                        state_d = S_SUGAR;
                        cnt_d   = sug_m1;
                    end else
`endif
                    if (mix_sel) begin
                        state_d = S_MIX;
                        cnt_d   = MIX_M1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef COFFEE_SUGAR_EN
            S_SUGAR: begin
                if (!sens_ok) begin
                    state_d = S_ERROR;
                end else if (cnt_q == '0) begin
                    if (mix_sel) begin
                        state_d = S_MIX;
                        cnt_d   = MIX_M1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            S_MIX: begin
                if (!sens_ok) begin
                    state_d = S_ERROR;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // DRINK is deliberately absent in CHECK and ERROR so an aborted brew never shows a recipe.
    assign phase_active = state_q inside {S_CUP, S_HEAT, S_POUR,
`ifdef COFFEE_SUGAR_EN
                                          S_SUGAR,
`endif
                                          S_MIX, S_DONE};

    assign bus.busy_o    = state_q != S_IDLE;
    assign bus.drink_o   = phase_active ? drink_oh : '0;
    assign bus.err_o     = (state_q == S_ERROR) ? ~bus.sens_i : '0;
    assign bus.bad_sel_o = bad_sel_q;
    assign bus.cup_o     = state_q == S_CUP;
    assign bus.heat_o    = state_q == S_HEAT;
    assign bus.pour_o    = state_q == S_POUR;
    assign bus.mix_o     = state_q == S_MIX;
    assign bus.done_o    = state_q == S_DONE;
`ifdef COFFEE_SUGAR_EN
    assign bus.sugar_o   = state_q == S_SUGAR;
`endif

endmodule
